// File: rtl/db_scan_ctrl.sv
// db_scan_ctrl: time-shared round-robin debouncer for N_CH switches with edge pulses and a 1-entry event buffer.
// Define DB_SYNC_EN to pass each sw bit through a 2-FF synchronizer before sampling.
module db_scan_ctrl #(
  parameter int N_CH        = 4,
  parameter int TICK_CYCLES = 131072,
  parameter int STABLE_CNT  = 4,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PW = $clog2(TICK_CYCLES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CW-1:0]   evt_ch,
  output logic            evt_level,
  output logic            evt_ovf,
  input  logic            ovf_clr
);
  typedef enum logic [1:0] {S_LO = 2'b00, S_WH = 2'b01, S_HI = 2'b10, S_WL = 2'b11} st_e;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   idx_q, idx_d;
  st_e             st_q [N_CH];
  logic [3:0]      cnt_q [N_CH];
  st_e             cur_st, nst;
  logic [3:0]      cur_cnt, ncnt;
  logic            s, commit, tick, push, xfer, load;
  logic [N_CH-1:0] s_vec, onehot, rise_q, rise_d, fall_q, fall_d;
  logic            evt_valid_q, evt_valid_d, evt_level_q, evt_level_d, evt_ovf_q, evt_ovf_d;
  logic [CW-1:0]   evt_ch_q, evt_ch_d;
`ifdef DB_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end
  assign s_vec = sync2_q;
`else
  assign s_vec = sw;
`endif
  assign tick   = pre_q == PW'(TICK_CYCLES - 1);
  assign pre_d  = tick ? '0 : pre_q + 1'b1;
  assign idx_d  = tick ? ((idx_q == CW'(N_CH - 1)) ? '0 : idx_q + 1'b1) : idx_q;
  assign onehot = N_CH'(1) << idx_q;
  assign cur_st  = st_q[idx_q];
  assign cur_cnt = cnt_q[idx_q];
  assign s       = s_vec[idx_q];
  // Only the channel under the scan pointer advances; the rest hold their state.
  always_comb begin
    nst    = cur_st;
    ncnt   = cur_cnt;
    commit = 1'b0;
    case (cur_st)
      S_LO: if (s) begin nst = S_WH; ncnt = 4'd1; end
      S_WH: begin
        if (!s) begin nst = S_LO; ncnt = 4'd0; end
        else if (cur_cnt == 4'(STABLE_CNT - 1)) begin nst = S_HI; ncnt = 4'd0; commit = 1'b1; end
        else ncnt = cur_cnt + 4'd1;
      end
      S_HI: if (!s) begin nst = S_WL; ncnt = 4'd1; end
      default: begin
        if (s) begin nst = S_HI; ncnt = 4'd0; end
        else if (cur_cnt == 4'(STABLE_CNT - 1)) begin nst = S_LO; ncnt = 4'd0; commit = 1'b1; end
        else ncnt = cur_cnt + 4'd1;
      end
    endcase
  end
  assign push        = tick && commit;
  assign rise_d      = (push && nst == S_HI) ? onehot : '0;
  assign fall_d      = (push && nst == S_LO) ? onehot : '0;
  assign xfer        = evt_valid_q && evt_ready;
  assign load        = push && (!evt_valid_q || xfer);
  assign evt_valid_d = push || (evt_valid_q && !xfer);
  assign evt_ch_d    = load ? idx_q : evt_ch_q;
  assign evt_level_d = load ? (nst == S_HI) : evt_level_q;
  assign evt_ovf_d   = (push && evt_valid_q && !xfer) || (evt_ovf_q && !ovf_clr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      idx_q       <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      evt_ovf_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= S_LO;
        cnt_q[i] <= 4'd0;
      end
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      evt_ovf_q   <= evt_ovf_d;
      if (tick) begin
        st_q[idx_q]  <= nst;
        cnt_q[idx_q] <= ncnt;
      end
    end
  end
  // The debounced level is the high bit of the state encoding (S_HI/S_WL).
  always_comb begin
    db = '0;
    for (int i = 0; i < N_CH; i++) db[i] = st_q[i][1];
  end
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_level = evt_level_q;
  assign evt_ovf   = evt_ovf_q;
endmodule

// File: tb/tb_db_scan_ctrl.sv
// tb_db_scan_ctrl: directed and random stimulus against a run-length debounce reference model.
module tb_db_scan_ctrl;
  localparam int N = 2, T = 4, S = 3;
  logic       clk = 1'b0, reset = 1'b1;
  logic [1:0] sw = '0, sw_next = '0;
  logic       evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [1:0] db, rise, fall;
  logic       evt_valid, evt_level, evt_ovf;
  logic [0:0] evt_ch;
  int n_chk = 0, n_err = 0;
  int m_pre, m_idx, m_ch;
  int m_run [N];
  bit [1:0] m_db, m_rise, m_fall;
  bit m_val, m_lvl, m_ovf;
  int r_cnt, f_cnt;
  bit found;

  db_scan_ctrl #(.N_CH(N), .TICK_CYCLES(T), .STABLE_CNT(S)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_level(evt_level),
    .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_ch = 0; m_db = '0; m_rise = '0; m_fall = '0;
    m_val = 0; m_lvl = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // A channel commits after S consecutive samples that differ from its debounced level.
  task automatic step(bit rdy, bit clr);
    int c;
    bit p, x;
    if (m_pre == 0) sw = sw_next;
    evt_ready = rdy;
    ovf_clr = clr;
    p = 0; c = m_idx; m_rise = '0; m_fall = '0;
    if (m_pre == T - 1) begin
      if (sw[c] != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == S) begin
          m_db[c] = sw[c]; m_run[c] = 0; p = 1;
          if (sw[c]) m_rise[c] = 1; else m_fall[c] = 1;
        end
      end else m_run[c] = 0;
      m_idx = (m_idx + 1) % N;
    end
    x = m_val && rdy;
    if (p && m_val && !x) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (p && (!m_val || x)) begin m_val = 1; m_ch = c; m_lvl = m_db[c]; end
    else if (x) m_val = 0;
    m_pre = (m_pre + 1) % T;
    @(posedge clk); #1;
    check("db", db, m_db);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("evt_valid", evt_valid, m_val);
    check("evt_ch", evt_ch, m_ch);
    check("evt_level", evt_level, m_lvl);
    check("evt_ovf", evt_ovf, m_ovf);
    r_cnt += rise[0];
    f_cnt += fall[0];
  endtask

  task automatic run(int n, logic [1:0] v, bit rdy, bit clr);
    sw_next = v;
    repeat (n) step(rdy, clr);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_out"}, {db, rise, fall, evt_valid, evt_ch, evt_level, evt_ovf}, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    // clean press on ch0
    r_cnt = 0;
    run(40, 2'b01, 0, 0);
    check("press_db0", db[0], 1);
    check("press_db1", db[1], 0);
    check("press_rise_cnt", r_cnt, 1);
    check("press_evt", {evt_valid, evt_ch, evt_level}, 3'b101);
    run(2, 2'b01, 1, 0);
    // release
    f_cnt = 0;
    run(40, 2'b00, 1, 0);
    check("release_db0", db[0], 0);
    check("release_fall_cnt", f_cnt, 1);
    // bounce: each ch0 sample alternates, never reaching S in a row
    r_cnt = 0; f_cnt = 0;
    for (int k = 0; k < 10; k++) run(8, (k % 2 == 0) ? 2'b01 : 2'b00, 0, 0);
    run(40, 2'b00, 0, 0);
    check("bounce_db0", db[0], 0);
    check("bounce_pulses", r_cnt + f_cnt, 0);
    check("bounce_valid", evt_valid, 0);
    // overflow
    run(40, 2'b01, 0, 0);
    run(40, 2'b11, 0, 0);
    check("ovf_buf", {evt_valid, evt_ch, evt_level}, 3'b101);
    check("ovf_set", evt_ovf, 1);
    run(1, 2'b11, 0, 1);
    check("ovf_clr", evt_ovf, 0);
    run(1, 2'b11, 1, 0);
    check("ovf_pop", evt_valid, 0);
    // push with simultaneous pop
    run(40, 2'b00, 1, 0);
    run(40, 2'b01, 0, 0);
    sw_next = 2'b11;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (m_pre == T - 1 && m_idx == 1 && m_run[1] == S - 1 && sw[1] != m_db[1]) begin
        step(1, 0);
        found = 1;
        check("pp_buf", {evt_valid, evt_ch, evt_level}, 3'b111);
        check("pp_ovf", evt_ovf, 0);
      end else step(0, 0);
    end
    check("pp_found", found, 1);
    // reset while ch0 is two samples into a rising qualification
    run(40, 2'b10, 1, 0);
    sw_next = 2'b11;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      step(0, 0);
      found = m_run[0] == 2;
    end
    check("rst_found", found, 1);
    check("rst_pre_db1", db[1], 1);
    #1 reset = 1'b1;
    #1 check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    run(16, 2'b11, 0, 0);
    check("rst_two_samples_db0", db[0], 0);
    run(8, 2'b11, 0, 0);
    check("rst_three_samples_db0", db[0], 1);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) sw_next = 2'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/db_scan_ctrl.md
Name: db_scan_ctrl

Overview:
- Multi-channel debounce scheduler. One shared sample timer and one shared debounce engine serve N_CH raw switch inputs, scanned round-robin.
- Produces a debounced level vector, one-cycle edge pulses, and a single-entry event interface (valid/ready) for the board-level controller that steps the single-cycle MIPS core from push buttons.
- Replaces per-switch debouncer instances with one time-shared engine plus small per-channel state.

Parameters:
- N_CH, 4, number of switch channels (1..16).
- TICK_CYCLES, 131072, clock cycles between scan ticks (>=2).
- STABLE_CNT, 4, consecutive equal samples of a channel required to commit a new level (2..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sw  in  N_CH  raw switch/button levels, asynchronous to clk.
- db  out  N_CH  debounced levels.
- rise  out  N_CH  one-cycle pulse when db[i] commits 0->1.
- fall  out  N_CH  one-cycle pulse when db[i] commits 1->0.
- evt_valid  out  1  event buffer holds an event.
- evt_ready  in  1  consumer accepts event.
- evt_ch  out  $clog2(N_CH) (min 1)  channel of the buffered event.
- evt_level  out  1  new committed level of the buffered event.
- evt_ovf  out  1  sticky: an event was dropped.
- ovf_clr  in  1  synchronous clear of evt_ovf.

Behaviour:
- Reset: db=0, rise=0, fall=0, evt_valid=0, evt_ch=0, evt_level=0, evt_ovf=0. Prescaler=0, scan_idx=0, all channels in S_LO with cnt=0, synchronizers=0. Reset mid-scan discards all in-progress counts; no pulses or events are generated on reset release.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps. tick=1 in the cycle the count is TICK_CYCLES-1.
- Scan: on tick, channel scan_idx is processed using its synchronized sample s. scan_idx then advances (N_CH-1 wraps to 0). Each channel is therefore sampled every N_CH*TICK_CYCLES cycles.
- Per-channel 2-bit FSM with a cnt[3:0]:
  - S_LO (db=0): s=1 -> S_WH, cnt=1. s=0 -> stay.
  - S_WH: s=1 and cnt==STABLE_CNT-1 -> S_HI and commit 1. s=1 otherwise -> cnt+1. s=0 -> S_LO, cnt=0.
  - S_HI (db=1): s=0 -> S_WL, cnt=1. s=1 -> stay.
  - S_WL: s=0 and cnt==STABLE_CNT-1 -> S_LO and commit 0. s=0 otherwise -> cnt+1. s=1 -> S_HI, cnt=0.
- Commit timing: registered. db[i], rise[i]/fall[i] and the event push all take effect in the cycle after the committing tick. rise/fall last exactly one cycle. At most one commit occurs per cycle.
- Event buffer (1 entry):
  - Transfer occurs when evt_valid && evt_ready.
  - Push with buffer empty: load evt_ch/evt_level, evt_valid=1.
  - Push with a simultaneous transfer: load the new event; evt_valid stays 1.
  - Push while full with no transfer: new event dropped, buffer unchanged, evt_ovf=1.
  - Transfer with no push: evt_valid=0.
  - evt_ch/evt_level hold stable while evt_valid=1 and not transferred.
- evt_ovf: ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- Channels not currently scanned hold their state. sw changes between ticks are invisible to the FSM.

Optional Feature:
- DB_SYNC_EN defined: each sw bit passes through a 2-FF synchronizer before sampling, adding 2 cycles input latency.
- Undefined: sw is sampled directly at tick. Intended only for benches with clk-aligned stimulus.
- All other behaviour is identical in both builds.

Test Plan:
Bench parameters: N_CH=2, TICK_CYCLES=4, STABLE_CNT=3, DB_SYNC_EN defined. Ch0 ticks every 8 cycles.
- Clean press: sw[0] 0->1 held -> db[0]=1 one cycle after the 3rd ch0 tick sampling 1; rise[0] high exactly 1 cycle; evt_valid=1 with evt_ch=0, evt_level=1; db[1] stays 0.
- Bounce: sw[0] toggles every 8 cycles for 80 cycles, then held 0 -> db[0] stays 0; no rise/fall pulses; evt_valid stays 0.
- Release: from db[0]=1, sw[0]=0 held -> fall[0] pulse, db[0]=0 after 3 ch0 samples; event level 0.
- Overflow: evt_ready=0; commit ch0 rise, then ch1 rise -> buffer keeps {ch0,1}, evt_ovf=1. Pulse ovf_clr -> evt_ovf=0. Set evt_ready=1 -> event transferred, evt_valid=0 next cycle.
- Push with pop: hold evt_ready=1 at the cycle of a ch1 commit while {ch0,1} is buffered -> buffer becomes {ch1,1}, evt_valid stays 1, evt_ovf stays 0.
- Reset mid-op: assert reset while ch0 is in S_WH with cnt=2 -> all outputs 0 immediately. After release with sw[0]=1, three fresh ch0 samples are needed before db[0]=1.
